// File: rtl/axi_stream_slave.sv
// AXI4-Stream video sink: registers each accepted beat and tracks pixel/line/frame position.
// Latency: one cycle from acceptance to data_valid. Optional SOF-mid-line check via AXIS_SLAVE_PROTOCOL_CHECK_EN.
// Backpressure: none; tready rises one edge after reset release and stays high.
module axi_stream_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  sof_out,
  output logic                  eol_out,
  output logic [CNT_WIDTH-1:0]  pixel_count,
  output logic [CNT_WIDTH-1:0]  line_count,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic                  protocol_err
);

  logic                 accept;
  logic [CNT_WIDTH-1:0] pix_nxt;
  logic [CNT_WIDTH-1:0] line_nxt;
  logic [CNT_WIDTH-1:0] frame_nxt;

  assign accept = s_axis_tvalid && s_axis_tready;

  // The tlast rule is applied on top of the tuser rule, so SOF+EOL yields line 1, pixel 0.
  always_comb begin
    pix_nxt   = pixel_count;
    line_nxt  = line_count;
    frame_nxt = frame_count;
    if (accept) begin
      if (s_axis_tuser) begin
        frame_nxt = frame_count + CNT_WIDTH'(1);
        line_nxt  = '0;
        pix_nxt   = CNT_WIDTH'(1);
      end else begin
        pix_nxt   = pixel_count + CNT_WIDTH'(1);
      end
      if (s_axis_tlast) begin
        pix_nxt  = '0;
        line_nxt = line_nxt + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_axis_tready <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      sof_out       <= 1'b0;
      eol_out       <= 1'b0;
      pixel_count   <= '0;
      line_count    <= '0;
      frame_count   <= '0;
    end else begin
      s_axis_tready <= 1'b1;
      data_valid    <= accept;
      sof_out       <= accept && s_axis_tuser;
      eol_out       <= accept && s_axis_tlast;
      if (accept) begin
        data_out <= s_axis_tdata;
      end
      pixel_count <= pix_nxt;
      line_count  <= line_nxt;
      frame_count <= frame_nxt;
    end
  end

`ifdef AXIS_SLAVE_PROTOCOL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept && s_axis_tuser && (pixel_count != '0)) begin
      err_q <= 1'b1;
    end
  end

  assign protocol_err = err_q;

  // Unknown payload while valid is only observable in simulation.
  assert property (@(posedge clk) disable iff (!rst_n)
    s_axis_tvalid |-> !$isunknown({s_axis_tdata, s_axis_tlast, s_axis_tuser}))
    else $error("axi_stream_slave: X/Z on stream payload while tvalid");
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_slave.sv
// Bench for axi_stream_slave: directed plan steps plus random traffic against a position model.
module tb_axi_stream_slave;
  localparam int DW = 32;
  localparam int CW = 6;
  localparam int CMOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          sof_out;
  logic          eol_out;
  logic [CW-1:0] pixel_count;
  logic [CW-1:0] line_count;
  logic [CW-1:0] frame_count;
  logic          protocol_err;

  axi_stream_slave #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .data_out(data_out),
    .data_valid(data_valid), .sof_out(sof_out), .eol_out(eol_out),
    .pixel_count(pixel_count), .line_count(line_count),
    .frame_count(frame_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: stream position as plain integers modulo 2^CW.
  int          m_pix, m_line, m_frame;
  logic [DW-1:0] m_data;
  bit          m_rdy, m_err;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input bit vld, input bit sof, input bit eol);
    chk("tready", DW'(s_axis_tready), DW'(m_rdy));
    chk("data_valid", DW'(data_valid), DW'(vld));
    chk("sof_out", DW'(sof_out), DW'(sof));
    chk("eol_out", DW'(eol_out), DW'(eol));
    chk("data_out", data_out, m_data);
    chk("pixel_count", DW'(pixel_count), DW'(m_pix));
    chk("line_count", DW'(line_count), DW'(m_line));
    chk("frame_count", DW'(frame_count), DW'(m_frame));
    chk("protocol_err", DW'(protocol_err), DW'(m_err));
  endtask

  task automatic model_clear();
    m_pix = 0; m_line = 0; m_frame = 0; m_data = '0; m_rdy = 0; m_err = 0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      model_clear();
      check_all(0, 0, 0);
    end
    rst_n = 1'b1;
    chk("tready_before_release_edge", DW'(s_axis_tready), DW'(0));
  endtask

  // One clock edge of stimulus; payload is randomised when tvalid is low to prove it is ignored.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit u);
    bit acc;
    s_axis_tvalid = v;
    s_axis_tdata  = v ? d : $urandom;
    s_axis_tlast  = v ? l : 1'($urandom);
    s_axis_tuser  = v ? u : 1'($urandom);
    @(posedge clk); #1;
    acc = v && m_rdy;
    if (acc) begin
      m_data = d;
`ifdef AXIS_SLAVE_PROTOCOL_CHECK_EN
      if (u && m_pix != 0) m_err = 1;
`endif
      if (u) begin
        m_frame = (m_frame + 1) % CMOD;
        m_line  = 0;
        m_pix   = 1;
      end else begin
        m_pix = (m_pix + 1) % CMOD;
      end
      if (l) begin
        m_pix  = 0;
        m_line = (m_line + 1) % CMOD;
      end
    end
    m_rdy = 1;
    check_all(acc, acc && u, acc && l);
  endtask

  initial begin
    model_clear();
    // Plan 1: reset and tready release.
    do_reset(2);
    step(0, '0, 0, 0);
    chk("counters_zero_after_reset", DW'({pixel_count, line_count, frame_count}), DW'(0));
    // Plan 2: single plain beat.
    step(1, 32'hA5A5A5A5, 0, 0);
    step(0, '0, 0, 0);
    // Plan 3: SOF beat then EOL beat.
    step(1, 32'h12345678, 0, 1);
    step(1, 32'hDEADBEEF, 1, 0);
    chk("plan3_frame", DW'(frame_count), DW'(1));
    chk("plan3_line", DW'(line_count), DW'(1));
    // Plan 4: back-to-back SOF+EOL then SOF.
    step(1, 32'hFACEFADE, 1, 1);
    chk("plan4a_state", DW'({frame_count, line_count, pixel_count}), DW'({6'd2, 6'd1, 6'd0}));
    step(1, 32'hABEDDEAF, 0, 1);
    chk("plan4b_state", DW'({frame_count, line_count, pixel_count}), DW'({6'd3, 6'd0, 6'd1}));
    step(0, '0, 0, 0);
    // Plan 5: held valid for three edges after a fresh line.
    step(1, 32'h0, 1, 0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 32'h11111111, 0, 0);
      chk("plan5_pix", DW'(pixel_count), DW'(i));
    end
    // Plan 6: two plain beats then SOF mid-line.
    step(1, 32'h1, 0, 0);
    step(1, 32'h2, 0, 0);
    step(1, 32'h3, 0, 1);
    step(0, '0, 0, 0);
    // Pixel and frame counter wrap.
    for (int i = 0; i < CMOD + 6; i++) step(1, DW'(i), 0, 0);
    for (int i = 0; i < CMOD + 3; i++) step(1, DW'(i), 1, 1);
    // Mid-stream reset.
    step(1, 32'hCAFE0001, 0, 0);
    do_reset(1);
    step(1, 32'hBAD0BAD0, 0, 0);
    step(1, 32'h00C0FFEE, 0, 1);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom,
           $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
    end
    do_reset(1);
    step(0, '0, 0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
